shift_ex_stage: RTL

// - EX-stage pipeline wrapper around the combinational Shifter (SLL/SRA/ROR, 16-bit).
// - Captures decoded shift ops from ID with valid/ready handshake and resolves operand forwarding.
// - Drives the Shifter from a registered operand stage and registers result plus Z flag toward MEM.
// - Two-entry pipeline (stage A = operands, stage B = result) with full back-pressure and flush.

---
 rtl/shift_ex_stage.sv | 109 ++++++++++
 1 files changed

// File: rtl/shift_ex_stage.sv
// shift_ex_stage: two-entry EX pipeline (operand stage A, result stage B) around a 16-bit SLL/SRA/ROR shifter
// Ports: clk/rst (async active-high), flush (sync squash of A and B)
//        id_valid/id_ready with id_op, id_rs_reg, id_rs_data, id_imm, id_rd (shift op from ID)
//        exmem_*/memwb_* forwarding sources (used only when SHIFT_EX_FWD_EN is defined)
//        ex_valid/ex_ready with ex_result, ex_rd toward MEM; flag_z is 1 when the last produced result was zero
// Config: define SHIFT_EX_FWD_EN to forward EX/MEM then MEM/WB results onto the source operand (R0 never forwarded)
module shift_ex_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [1:0]         id_op,
  input  logic [REG_W-1:0]   id_rs_reg,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [SHAMT_W-1:0] id_imm,
  input  logic [REG_W-1:0]   id_rd_reg,
  input  logic               exmem_wr_en,
  input  logic [REG_W-1:0]   exmem_rd,
  input  logic [DATA_W-1:0]  exmem_data,
  input  logic               memwb_wr_en,
  input  logic [REG_W-1:0]   memwb_rd,
  input  logic [DATA_W-1:0]  memwb_data,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [DATA_W-1:0]  ex_result,
  output logic [REG_W-1:0]   ex_rd,
  output logic               flag_z
);
  logic               r_a_valid;
  logic [1:0]         r_a_op;
  logic [DATA_W-1:0]  r_a_opnd;
  logic [SHAMT_W-1:0] r_a_imm;
  logic [REG_W-1:0]   r_a_rd;
  logic               r_b_valid;
  logic [DATA_W-1:0]  r_result;
  logic [REG_W-1:0]   r_rd;
  logic               r_z;
  logic               w_adv_b;
  logic               w_take;
  logic [DATA_W-1:0]  w_opnd;
  logic [DATA_W-1:0]  w_sll;
  logic [DATA_W-1:0]  w_sra;
  logic [DATA_W-1:0]  w_ror;
  logic [DATA_W-1:0]  w_shift;
`ifdef SHIFT_EX_FWD_EN
  // EX/MEM is younger than MEM/WB, so it wins when both target the same register
  assign w_opnd = (exmem_wr_en && exmem_rd == id_rs_reg && id_rs_reg != '0) ? exmem_data :
                  (memwb_wr_en && memwb_rd == id_rs_reg && id_rs_reg != '0) ? memwb_data :
                  id_rs_data;
`else
  logic w_unused;
  assign w_unused = ^{exmem_wr_en, exmem_rd, exmem_data, memwb_wr_en, memwb_rd, memwb_data, id_rs_reg};
  assign w_opnd   = id_rs_data;
`endif
  assign w_adv_b   = r_a_valid && (!r_b_valid || ex_ready);
  assign id_ready  = !r_a_valid || w_adv_b;
  assign w_take    = id_valid && id_ready;
  assign w_sll     = r_a_opnd << r_a_imm;
  assign w_sra     = $signed(r_a_opnd) >>> r_a_imm;
  // rotate by shifting a doubled copy and keeping the low half
  assign w_ror     = DATA_W'({r_a_opnd, r_a_opnd} >> r_a_imm);
  assign w_shift   = r_a_op[1] ? w_ror : r_a_op[0] ? w_sra : w_sll;
  assign ex_valid  = r_b_valid;
  assign ex_result = r_result;
  assign ex_rd     = r_rd;
  assign flag_z    = r_z;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_op    <= '0;
      r_a_opnd  <= '0;
      r_a_imm   <= '0;
      r_a_rd    <= '0;
    end else if (flush) begin
      r_a_valid <= 1'b0;
    end else if (w_take) begin
      r_a_valid <= 1'b1;
      r_a_op    <= id_op;
      r_a_opnd  <= w_opnd;
      r_a_imm   <= id_imm;
      r_a_rd    <= id_rd_reg;
    end else if (w_adv_b) begin
      r_a_valid <= 1'b0;
    end
  end
  // flag_z is only touched when a new result lands in B, so flush leaves it intact
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b_valid <= 1'b0;
      r_result  <= '0;
      r_rd      <= '0;
      r_z       <= 1'b0;
    end else if (flush) begin
      r_b_valid <= 1'b0;
    end else if (w_adv_b) begin
      r_b_valid <= 1'b1;
      r_result  <= w_shift;
      r_rd      <= r_a_rd;
      r_z       <= (w_shift == '0);
    end else if (ex_ready) begin
      r_b_valid <= 1'b0;
    end
  end
endmodule
